// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg -- shared types and constants for the instruction-fetch slice.
//
// Contents:
//   XLEN          default address / instruction width
//   fetch_state_t fetch sequencer states (IDLE, WAIT, SQUASH)
//   fetch_entry_t one fetch-buffer entry: {pc, instr}
//   NOP           canonical addi x0,x0,0, used downstream for bubbles
// ---------------------------------------------------------------------------
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // WAIT keeps the returning word, SQUASH throws it away (redirect happened
  // while the request was in flight).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if -- bus bundle between the fetch unit, instruction memory
// and the IF/ID stage.
//
// Signals:
//   imem_req_valid / imem_req_ready / imem_req_addr   fetch request
//   imem_rsp_valid / imem_rsp_data                    fetch response
//   id_valid / id_ready / id_instr / id_pc            buffer head to IF/ID
//
// Modports:
//   master  the fetch unit side
//   slave   the environment side (memory + IF/ID)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int XLEN = if_pkg::XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output id_valid, id_instr, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_instr, id_pc,
    output id_ready
  );

endinterface

// File: rtl/if_fetch_unit_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer -- small FIFO of fetched {pc, instr} entries.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   push, entry    write one entry at the tail
//   pop            drop the head entry
//   clear          empty the FIFO at the next edge (wins over push/pop)
//   count          number of valid entries (0..DEPTH)
//   head           entry at the head (meaningful only when count != 0)
//
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_buffer
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fetch_entry_t             entry,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count_q;

  // Storage is reset too so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign count = count_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch sequencer between the PC register,
// instruction memory and the IF/ID stage.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   IF_PC         current fetch address from the PC register
//   PCWrite       PC load enable (one pulse per accepted request, or flush)
//   flush         redirect from EX; the PC loads the target when PCWrite=1
//   bus           if_fetch_unit_if.master: imem request/response + IF/ID
//
// At most one memory request is outstanding. A new request is only issued
// when the buffer is guaranteed to have room for its response, so the FIFO
// can never overflow.
// ---------------------------------------------------------------------------
module fetch_unit_dummy_guard;
endmodule

module if_fetch_unit
  import if_pkg::*;
#(
  parameter int XLEN      = if_pkg::XLEN,
  parameter int BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PCWrite,
  input  logic            flush,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    state_q;
  fetch_state_t    state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [CW-1:0]   buf_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            in_flight;
  logic            rsp_kept;
  logic            credit;
  logic            issue;
  logic            accept;
  logic            push;
  logic            pop;

  assign in_flight = (state_q == WAIT) || (state_q == SQUASH);
  assign rsp_kept  = (state_q == WAIT) && bus.imem_rsp_valid;

  // Credit uses the registered count: a same-cycle dequeue is not counted,
  // which keeps the path from id_ready to imem_req_valid short.
  assign credit = (buf_count + CW'(rsp_kept)) < CW'(BUF_DEPTH);

  assign issue = !flush && credit &&
                 ((state_q == IDLE) || (in_flight && bus.imem_rsp_valid));

  assign bus.imem_req_valid = issue && reset_n;
  assign bus.imem_req_addr  = IF_PC;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign PCWrite            = (accept || flush) && reset_n;

  assign push             = rsp_kept && !flush;
  assign push_entry.pc    = req_pc_q;
  assign push_entry.instr = bus.imem_rsp_data;

  assign bus.id_valid = (buf_count != '0) && !flush && reset_n;
  assign pop          = bus.id_valid && bus.id_ready;
  assign bus.id_pc    = head.pc;
  assign bus.id_instr = head.instr;

  // State register plus the PC of the request currently in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_pc_q <= IF_PC;
      end
    end
  end

  // Next state: a response retires the outstanding request unless a new one
  // is accepted in the same cycle; a flush turns a pending request into a
  // squashed one so its data is dropped when it arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = bus.imem_rsp_valid ? IDLE : SQUASH;
        end else if (bus.imem_rsp_valid) begin
          state_d = accept ? WAIT : IDLE;
        end
      end
      SQUASH: begin
        if (bus.imem_rsp_valid) begin
          state_d = accept ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .entry  (push_entry),
    .pop    (pop),
    .clear  (flush),
    .count  (buf_count),
    .head   (head)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit -- self-checking bench for if_fetch_unit.
//
// The bench plays the PC register and the instruction memory, and keeps a
// queue-based reference model of what the fetch unit must present each
// cycle. Directed scenarios pin the model with literal values, then a long
// randomized run exercises backpressure, flushes, latency and resets.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IF_PC = '0;
  logic        PCWrite;
  logic        flush = 1'b0;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(
    .XLEN     (32),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .IF_PC  (IF_PC),
    .PCWrite(PCWrite),
    .flush  (flush),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // Stimulus knobs, applied at each falling edge.
  bit          k_reset_n   = 1'b0;
  bit          k_req_ready = 1'b0;
  bit          k_id_ready  = 1'b0;
  bit          k_flush     = 1'b0;
  bit          k_spurious  = 1'b0;
  logic [31:0] k_target    = '0;
  int          k_lat       = 1;

  // Instruction memory environment: one pending response at most.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Reference model: outstanding request and buffered entries.
  bit           m_out    = 1'b0;
  bit           m_sq     = 1'b0;
  logic [31:0]  m_out_pc = '0;
  fetch_entry_t m_q[$];

  // Expectations / observations of the current cycle.
  bit          e_rv, e_pw, e_idv, e_acc, e_kept, e_rh;
  logic [31:0] e_head_pc, e_head_in;
  bit          obs_rv, obs_pw, obs_idv, obs_acc, obs_rsp;
  logic [31:0] obs_addr, obs_idpc, obs_idin, obs_rsp_data;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle, got, exp);
    end
  endtask

  // Drive inputs for the coming cycle, including the memory response.
  task automatic applyStimulus();
    reset_n            = k_reset_n;
    flush              = k_flush;
    bus.imem_req_ready = k_req_ready;
    bus.id_ready       = k_id_ready;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instr_of(mem_addr);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        mem_cnt--;
      end
    end else begin
      bus.imem_rsp_valid = k_spurious;
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  // Derive what the unit must show this cycle and compare.
  task automatic checkOutput();
    if (!reset_n) begin
      m_out = 1'b0; m_sq = 1'b0; m_q.delete();
      e_rv = 1'b0; e_pw = 1'b0; e_idv = 1'b0; e_acc = 1'b0;
      e_kept = 1'b0; e_rh = 1'b0; e_head_pc = '0; e_head_in = '0;
    end else begin
      e_rh   = m_out && bus.imem_rsp_valid;
      e_kept = e_rh && !m_sq;
      e_rv   = !flush && ((m_q.size() + (e_kept ? 1 : 0)) < DEPTH) && (!m_out || e_rh);
      e_acc  = e_rv && bus.imem_req_ready;
      e_pw   = e_acc || flush;
      e_idv  = (m_q.size() != 0) && !flush;
      e_head_pc = (m_q.size() != 0) ? m_q[0].pc : '0;
      e_head_in = (m_q.size() != 0) ? m_q[0].instr : '0;
    end
    obs_rv       = bus.imem_req_valid;
    obs_pw       = PCWrite;
    obs_idv      = bus.id_valid;
    obs_addr     = bus.imem_req_addr;
    obs_idpc     = bus.id_pc;
    obs_idin     = bus.id_instr;
    obs_acc      = bus.imem_req_valid && bus.imem_req_ready;
    obs_rsp      = bus.imem_rsp_valid;
    obs_rsp_data = bus.imem_rsp_data;
    cmp("req_valid", {31'd0, obs_rv}, {31'd0, e_rv});
    cmp("pc_write", {31'd0, obs_pw}, {31'd0, e_pw});
    cmp("req_addr", obs_addr, IF_PC);
    cmp("id_valid", {31'd0, obs_idv}, {31'd0, e_idv});
    if (!reset_n || e_idv) begin
      cmp("id_pc", obs_idpc, e_head_pc);
      cmp("id_instr", obs_idin, e_head_in);
    end
  endtask

  // Advance model and environment after the active edge.
  task automatic updateState();
    fetch_entry_t ent;
    if (reset_n) begin
      if (e_idv && k_id_ready) void'(m_q.pop_front());
      if (k_flush) begin
        m_q.delete();
      end else if (e_kept) begin
        ent.pc    = m_out_pc;
        ent.instr = obs_rsp_data;
        m_q.push_back(ent);
      end
      if (e_rh) m_out = 1'b0;
      if (k_flush && m_out) m_sq = 1'b1;
      if (e_acc) begin
        m_out = 1'b1; m_sq = 1'b0; m_out_pc = IF_PC;
      end
    end
    if (mem_busy && obs_rsp) mem_busy = 1'b0;
    if (obs_acc) begin
      mem_busy = 1'b1; mem_cnt = k_lat; mem_addr = obs_addr;
    end
    if (!reset_n) IF_PC = '0;
    else if (obs_pw) IF_PC = k_flush ? k_target : IF_PC + 32'd4;
  endtask

  task automatic runCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    updateState();
    cycle++;
  endtask

  task automatic resetDut(input bit keep_mem);
    k_reset_n = 1'b0; k_flush = 1'b0; k_req_ready = 1'b0;
    k_id_ready = 1'b0; k_spurious = 1'b0;
    if (!keep_mem) mem_busy = 1'b0;
    runCycle();
    runCycle();
    k_reset_n = 1'b1;
  endtask

  initial begin
    int pulses;
    logic [31:0] drained[$];
    bit pw_log[8];
    bit iv_log[8];
    logic [31:0] pc_log[8];
    logic [31:0] in_log[8];
    logic [31:0] epc_log[8];

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;

    // Streaming with 1-cycle memory.
    resetDut(1'b0);
    k_req_ready = 1'b1; k_id_ready = 1'b1; k_lat = 1;
    for (int i = 0; i < 6; i++) begin
      runCycle();
      pw_log[i] = obs_pw; iv_log[i] = obs_idv;
      pc_log[i] = obs_idpc; in_log[i] = obs_idin; epc_log[i] = e_head_pc;
    end
    for (int i = 0; i < 5; i++) cmp("stream_pcwrite", {31'd0, pw_log[i]}, 32'd1);
    cmp("stream_idv0", {31'd0, iv_log[1]}, 32'd0);
    for (int i = 2; i < 5; i++) cmp("stream_idv", {31'd0, iv_log[i]}, 32'd1);
    cmp("stream_pc0", pc_log[2], 32'h0);
    cmp("stream_pc1", pc_log[3], 32'h4);
    cmp("stream_pc2", pc_log[4], 32'h8);
    cmp("stream_in0", in_log[2], instr_of(32'h0));
    cmp("stream_in2", in_log[4], instr_of(32'h8));
    cmp("model_pc1", epc_log[3], 32'h4);

    // IF/ID stalled: exactly DEPTH requests, then drain in order.
    resetDut(1'b0);
    k_req_ready = 1'b1; k_id_ready = 1'b0; k_lat = 1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      runCycle();
      if (obs_pw) pulses++;
    end
    cmp("stall_accepts", pulses, 32'd4);
    cmp("stall_req_valid", {31'd0, obs_rv}, 32'd0);
    cmp("stall_pcwrite", {31'd0, obs_pw}, 32'd0);
    cmp("stall_pc_held", IF_PC, 32'h10);
    k_id_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      runCycle();
      if (obs_idv) drained.push_back(obs_idpc);
      if (obs_pw) pulses++;
    end
    cmp("drain_count", (drained.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cmp("drain_pc", (i < drained.size()) ? drained[i] : 32'hFFFF_FFFF, 32'(i * 4));
    end
    cmp("drain_resumes", (pulses > 0) ? 32'd1 : 32'd0, 32'd1);

    // Memory not ready for 3 cycles at 0x20.
    resetDut(1'b0);
    IF_PC = 32'h20; k_lat = 3; k_id_ready = 1'b1; k_req_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      runCycle();
      cmp("hold_req_valid", {31'd0, obs_rv}, 32'd1);
      cmp("hold_addr", obs_addr, 32'h20);
      cmp("hold_pcwrite", {31'd0, obs_pw}, 32'd0);
    end
    k_req_ready = 1'b1;
    runCycle();
    if (obs_pw) pulses++;
    k_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      runCycle();
      if (obs_pw) pulses++;
    end
    cmp("hold_pulses", pulses, 32'd1);

    // Flush while a request for 0x40 is pending.
    resetDut(1'b0);
    IF_PC = 32'h40; k_lat = 3; k_id_ready = 1'b1; k_req_ready = 1'b1;
    runCycle();
    cmp("sq_first_addr", obs_addr, 32'h40);
    k_flush = 1'b1; k_target = 32'h100;
    runCycle();
    cmp("sq_flush_pcwrite", {31'd0, obs_pw}, 32'd1);
    cmp("sq_flush_req", {31'd0, obs_rv}, 32'd0);
    k_flush = 1'b0; k_lat = 1;
    runCycle();
    cmp("sq_wait_idv", {31'd0, obs_idv}, 32'd0);
    runCycle();
    cmp("sq_redirect_addr", obs_addr, 32'h100);
    cmp("sq_redirect_acc", {31'd0, obs_acc}, 32'd1);
    cmp("sq_drop_idv", {31'd0, obs_idv}, 32'd0);
    runCycle();
    cmp("sq_rsp_idv", {31'd0, obs_idv}, 32'd0);
    runCycle();
    cmp("sq_target_idv", {31'd0, obs_idv}, 32'd1);
    cmp("sq_target_pc", obs_idpc, 32'h100);
    cmp("sq_target_in", obs_idin, instr_of(32'h100));

    // Flush against a full buffer, then flush coincident with a response.
    resetDut(1'b0);
    k_req_ready = 1'b1; k_id_ready = 1'b0; k_lat = 1;
    for (int i = 0; i < 6; i++) runCycle();
    k_flush = 1'b1; k_spurious = 1'b1; k_target = 32'h200;
    runCycle();
    cmp("full_flush_idv", {31'd0, obs_idv}, 32'd0);
    cmp("full_flush_pcwrite", {31'd0, obs_pw}, 32'd1);
    k_flush = 1'b0; k_spurious = 1'b0; k_req_ready = 1'b0;
    runCycle();
    cmp("full_after_idv", {31'd0, obs_idv}, 32'd0);
    k_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) runCycle();
    k_flush = 1'b1; k_target = 32'h300;
    runCycle();
    cmp("rsp_flush_seen", {31'd0, obs_rsp}, 32'd1);
    cmp("rsp_flush_idv", {31'd0, obs_idv}, 32'd0);
    cmp("rsp_flush_pcwrite", {31'd0, obs_pw}, 32'd1);
    k_flush = 1'b0; k_req_ready = 1'b0;
    runCycle();
    cmp("rsp_after_idv", {31'd0, obs_idv}, 32'd0);

    // Reset while waiting; the late response must be ignored.
    resetDut(1'b0);
    k_req_ready = 1'b1; k_id_ready = 1'b1; k_lat = 5;
    runCycle();
    k_req_ready = 1'b0;
    runCycle();
    k_reset_n = 1'b0;
    runCycle();
    k_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      runCycle();
      cmp("stale_idv", {31'd0, obs_idv}, 32'd0);
    end
    cmp("stale_rsp_seen", {31'd0, obs_rsp}, 32'd1);
    k_req_ready = 1'b1; k_lat = 1;
    runCycle();
    cmp("restart_addr", obs_addr, 32'h0);
    cmp("restart_pcwrite", {31'd0, obs_pw}, 32'd1);
    runCycle();
    runCycle();
    cmp("restart_idv", {31'd0, obs_idv}, 32'd1);
    cmp("restart_pc", obs_idpc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      k_reset_n   = ($urandom_range(0, 199) != 0);
      k_req_ready = ($urandom_range(0, 9) < 7);
      k_id_ready  = ($urandom_range(0, 9) < 6);
      k_flush     = ($urandom_range(0, 15) == 0);
      k_spurious  = ($urandom_range(0, 19) == 0);
      k_target    = {$urandom_range(0, 16'hFFFF), 2'b00};
      k_lat       = $urandom_range(1, 3);
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch sequencer. It consumes the fetch address held in the PC register and returns the PC register's write enable.
- Issues one instruction-memory request per PC value and tracks the outstanding response.
- Buffers returned instructions in a small FIFO that feeds the IF/ID stage.
- PC advance, stall (backpressure) and redirect-squash all originate here, sitting between the PC register, instruction memory and IF/ID.

Parameters:
- XLEN, 32, address/instruction width.
- BUF_DEPTH, 4, fetch-buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- IF_PC  in  XLEN  current fetch address from the PC register
- PCWrite  out  1  PC load enable; PC takes nextPC on the clock edge when high
- flush  in  1  redirect/flush from EX; nextPC carries the target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  XLEN  request address; always equals IF_PC
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  XLEN  instruction word
- id_valid  out  1  buffer head valid toward IF/ID
- id_ready  in  1  IF/ID consumes the head
- id_instr  out  XLEN  head instruction
- id_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, buffer empty, req_pc=0.
  - id_valid=0, imem_req_valid=0, PCWrite=0; all three are gated low while reset_n is low.
  - id_instr and id_pc read 0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, result kept.
  - SQUASH: one request outstanding, result discarded.
- Issue condition:
  - Formula: issue = !flush && credit && (IDLE || ((WAIT || SQUASH) && imem_rsp_valid)).
  - Credit: credit = buf_count + (WAIT && imem_rsp_valid) < BUF_DEPTH, using the registered buf_count; a same-cycle dequeue is not credited.
- Request signals:
  - imem_req_valid = issue.
  - imem_req_addr = IF_PC.
  - The memory tolerates valid dropping without acceptance; IF_PC is stable because the PC holds while PCWrite=0.
- Acceptance (imem_req_valid && imem_req_ready):
  - req_pc <= IF_PC; state <= WAIT.
  - At most one request is outstanding.
- PCWrite = (imem_req_valid && imem_req_ready) || flush. It is combinational and one pulse per accepted request.
- Responses:
  - Memory response latency is >= 1 cycle after acceptance.
  - In WAIT, rsp_valid pushes {req_pc, rsp_data} into the buffer; state goes to IDLE, or stays WAIT if a new request is accepted the same cycle.
  - In SQUASH, rsp_valid drops the data; state goes to IDLE, or WAIT on a same-cycle accept.
  - rsp_valid in IDLE is ignored.
- Buffer:
  - FIFO with id_valid = (buf_count != 0) && !flush.
  - Dequeue when id_valid && id_ready.
  - Simultaneous push/pop keeps the count.
  - Pointers wrap modulo BUF_DEPTH.
  - A push never occurs when full; credit guarantees this.
- Flush in cycle t:
  - The buffer is cleared at the edge.
  - WAIT becomes SQUASH, or IDLE if rsp_valid arrives in t; that response is dropped.
  - No request is issued in t.
  - PCWrite=1 loads the redirect target.
  - A request is issued earliest in t+1.
  - Flush while IDLE clears the buffer only.
  - Flush in SQUASH stays SQUASH, or goes to IDLE on rsp_valid.
- Throughput: back-to-back 1 instr/cycle with 1-cycle memory, when id_ready=1 and BUF_DEPTH >= 4.
- Reset mid-operation: the outstanding response is forgotten immediately; a late rsp_valid after reset is ignored, since the state is IDLE.

Decomposition:
- Package if_pkg:
  - XLEN default.
  - Fetch state enum: IDLE=2'd0, WAIT=2'd1, SQUASH=2'd2.
  - Buffer entry struct {pc, instr}.
  - NOP constant 32'h00000013 for downstream bubble insertion.
- Sub-module fetch_buffer: parameterised FIFO with push/pop/clear, count, head outputs and async reset.

Test Plan:
- Reset then release, memory ready=1 with 1-cycle latency, IF_PC stepping 0,4,8:
  - PCWrite pulses every cycle.
  - id outputs (pc,instr) arrive as (0,I0), (4,I1), (8,I2) on consecutive cycles, starting 2 cycles after the first accept.
- id_ready=0 with a continuously responding memory:
  - Exactly BUF_DEPTH=4 requests are accepted, then imem_req_valid=0 and PCWrite=0 with IF_PC held at 16.
  - Raising id_ready drains the entries at pc 0,4,8,12 in order and fetching resumes.
- imem_req_ready=0 for 3 cycles at IF_PC=0x20:
  - imem_req_valid=1 and imem_req_addr=0x20 are held, with PCWrite=0.
  - On ready, exactly one PCWrite pulse.
- Flush while WAIT, with the response for 0x40 arriving 2 cycles later:
  - State goes to SQUASH and the response is discarded; id_valid stays 0.
  - The next accepted address is the redirect target, e.g. 0x100, whose instruction appears with id_pc=0x100.
- Flush coincident with rsp_valid and with a full buffer:
  - The buffer is empty next cycle, the response is dropped, and id_valid=0 in the flush cycle.
  - PCWrite=1 in the flush cycle.
- Assert reset_n low during WAIT, then release; memory returns a stale rsp_valid after release:
  - Stale response ignored, id_valid stays 0, fetch restarts from IF_PC=0.
